testboard_bist: RTL

- Automatic stimulus generator and response checker for the single-gate logic testboard; replaces manual switch toggling and LED inspection.
- Drives the 3 shared gate inputs (A/B/C) and exhaustively walks all 8 input vectors.
- Samples the 16 gate outputs, compares them against a golden model, and reports pass/fail plus a per-gate error mask.
- Sits on the board controller, between the gate array and the status indicators.

---
 rtl/testboard_bist_pkg.sv | 59 +++++
 rtl/testboard_bist_sync.sv | 23 ++
 rtl/testboard_bist.sv | 135 +++++++++++++
 3 files changed

// File: rtl/testboard_bist_pkg.sv
// Shared definitions for the testboard BIST: gate indices, FSM states and the
// golden truth model of the 16-gate array. Optional macro: TESTBOARD_BIST_FAILCAP_EN.
package testboard_bist_pkg;

  localparam int NUM_GATES = 16;
  localparam int NUM_VECS  = 8;

  localparam int GATE_ZBUF  = 0;
  localparam int GATE_BUF   = 1;
  localparam int GATE_INV   = 2;
  localparam int GATE_MUX   = 3;
  localparam int GATE_AND2  = 4;
  localparam int GATE_AND3  = 5;
  localparam int GATE_NAND2 = 6;
  localparam int GATE_NAND3 = 7;
  localparam int GATE_OR2   = 8;
  localparam int GATE_OR3   = 9;
  localparam int GATE_NOR2  = 10;
  localparam int GATE_NOR3  = 11;
  localparam int GATE_AO21  = 12;
  localparam int GATE_OA21  = 13;
  localparam int GATE_XOR2  = 14;
  localparam int GATE_XOR3  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Stimulus bit order on the board: [0]=A, [1]=B, [2]=C.
  function automatic logic [NUM_GATES-1:0] expected(input logic [2:0] v);
    logic a, b, c;
    logic [NUM_GATES-1:0] e;
    a = v[0];
    b = v[1];
    c = v[2];
    e = '0;
    e[GATE_ZBUF]  = a;
    e[GATE_BUF]   = a;
    e[GATE_INV]   = ~a;
    e[GATE_MUX]   = c ? b : a;
    e[GATE_AND2]  = a & b;
    e[GATE_AND3]  = a & b & c;
    e[GATE_NAND2] = ~(a & b);
    e[GATE_NAND3] = ~(a & b & c);
    e[GATE_OR2]   = a | b;
    e[GATE_OR3]   = a | b | c;
    e[GATE_NOR2]  = ~(a | b);
    e[GATE_NOR3]  = ~(a | b | c);
    e[GATE_AO21]  = (a & b) | c;
    e[GATE_OA21]  = (a | b) & c;
    e[GATE_XOR2]  = a ^ b;
    e[GATE_XOR3]  = a ^ b ^ c;
    return e;
  endfunction

endpackage

// File: rtl/testboard_bist_sync.sv
// Two-flop synchronizer for the gate-array outputs, which are not timed to clk_i.
module testboard_bist_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/testboard_bist.sv
// Testboard BIST: sweeps A/B/C over all vectors, checks the 16 gate outputs against
// the golden model. Optional macro TESTBOARD_BIST_FAILCAP_EN adds first-fail capture.
//
// state  | meaning
// IDLE   | waiting for start_i after reset
// SETTLE | stimulus applied, waiting for gates and synchronizer to settle
// CHECK  | one cycle: fold masked mismatches into err_mask_o, step vector
// DONE   | result valid; start_i launches a new run
module testboard_bist
  import testboard_bist_pkg::*;
#(
  parameter int              SETTLE_CYCLES = 16,
  parameter int              NUM_PASSES    = 1,
  parameter logic [15:0]     GATE_MASK     = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [2:0]           stim_o,
  input  logic [NUM_GATES-1:0] result_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
`ifdef TESTBOARD_BIST_FAILCAP_EN
  output logic                 fail_valid_o,
  output logic [2:0]           fail_vec_o,
`endif
  output logic [NUM_GATES-1:0] err_mask_o
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 2);
  localparam int PASS_W = $clog2(NUM_PASSES + 1);
  // SETTLE lasts SETTLE_CYCLES+2 cycles: the extra two cover the synchronizer.
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES + 1);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);
  localparam logic [2:0]        LAST_VEC    = 3'(NUM_VECS - 1);

  state_t                state;
  logic [2:0]            vec;
  logic [PASS_W-1:0]     pass_cnt;
  logic [CNT_W-1:0]      settle_cnt;
  logic [NUM_GATES-1:0]  sync_result;
  logic [NUM_GATES-1:0]  mismatch;

  testboard_bist_sync #(.WIDTH(NUM_GATES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .din    (result_i),
    .dout   (sync_result)
  );

  assign mismatch = (sync_result ^ expected(vec)) & GATE_MASK;
  assign stim_o   = vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_mask_o <= '0;
`ifdef TESTBOARD_BIST_FAILCAP_EN
      fail_valid_o <= 1'b0;
      fail_vec_o   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= SETTLE;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= SETTLE_LOAD;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_mask_o <= '0;
`ifdef TESTBOARD_BIST_FAILCAP_EN
            fail_valid_o <= 1'b0;
            fail_vec_o   <= '0;
`endif
          end
        end
        SETTLE: begin
          if (abort_i) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CHECK: begin
          if (abort_i) begin
            // An aborted CHECK leaves the mask as it was.
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= 1'b0;
          end else begin
            err_mask_o <= err_mask_o | mismatch;
`ifdef TESTBOARD_BIST_FAILCAP_EN
            if (!fail_valid_o && (mismatch != '0)) begin
              fail_valid_o <= 1'b1;
              fail_vec_o   <= vec;
            end
`endif
            if ((vec == LAST_VEC) && (pass_cnt == LAST_PASS)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= ((err_mask_o | mismatch) == '0);
            end else begin
              if (vec == LAST_VEC) begin
                pass_cnt <= pass_cnt + 1'b1;
              end
              vec        <= vec + 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
